// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs the load/store handshake with the data-memory
// controller, stalls upstream while waiting, and feeds write-back. Optional: MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mem_readmem,
  input  logic        ex_mem_writemem,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_selwsource,
  input  logic [4:0]  ex_mem_regdest,
  input  logic        ex_mem_writereg,
  input  logic [31:0] ex_mem_wbvalue,
  output logic        mem_mc_en,
  output logic        mem_mc_rw,
  output logic [31:0] mem_mc_addr,
  output logic [31:0] mem_mc_wdata,
  input  logic [31:0] mc_mem_rdata,
  input  logic        mc_mem_ready,
  output logic        mem_stall,
  output logic [4:0]  mem_wb_regdest,
  output logic        mem_wb_writereg,
  output logic [31:0] mem_wb_wbvalue,
  output logic        mem_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d, rw_q, rw_d, stall_q, stall_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]  wb_regdest_q, wb_regdest_d;
  logic        wb_writereg_q, wb_writereg_d;
  logic [31:0] wb_wbvalue_q, wb_wbvalue_d;
  logic        selw_q, selw_d, wr_lat_q, wr_lat_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic        mem_op_s;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  assign mem_op_s = ex_mem_readmem | ex_mem_writemem;

  // Next-state and next-output selection for the IDLE/WAIT handshake.
  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    rw_d          = rw_q;
    stall_d       = stall_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wb_regdest_d  = wb_regdest_q;
    wb_writereg_d = wb_writereg_q;
    wb_wbvalue_d  = wb_wbvalue_q;
    selw_d        = selw_q;
    rd_lat_d      = rd_lat_q;
    wr_lat_d      = wr_lat_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          state_d       = WAIT;
          en_d          = 1'b1;
          stall_d       = 1'b1;
          rw_d          = ex_mem_writemem;  // read+write together resolves to a write
          addr_d        = ex_mem_wbvalue;
          wdata_d       = ex_mem_regb;
          selw_d        = ex_mem_selwsource;
          rd_lat_d      = ex_mem_regdest;
          wr_lat_d      = ex_mem_writereg;
          wb_writereg_d = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end else begin
          wb_wbvalue_d  = ex_mem_wbvalue;
          wb_regdest_d  = ex_mem_regdest;
          wb_writereg_d = ex_mem_writereg;
        end
      end
      WAIT: begin
        if (mc_mem_ready) begin
          state_d       = IDLE;
          en_d          = 1'b0;
          stall_d       = 1'b0;
          wb_wbvalue_d  = selw_q ? mc_mem_rdata : addr_q;
          wb_regdest_d  = rd_lat_q;
          wb_writereg_d = wr_lat_q;
        end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d       = IDLE;
            en_d          = 1'b0;
            stall_d       = 1'b0;
            wb_writereg_d = 1'b0;
            err_d         = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          state_d = WAIT;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        stall_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      rw_q          <= 1'b0;
      stall_q       <= 1'b0;
      addr_q        <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      wb_regdest_q  <= 5'd0;
      wb_writereg_q <= 1'b0;
      wb_wbvalue_q  <= 32'h0000_0000;
      selw_q        <= 1'b0;
      rd_lat_q      <= 5'd0;
      wr_lat_q      <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      rw_q          <= rw_d;
      stall_q       <= stall_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wb_regdest_q  <= wb_regdest_d;
      wb_writereg_q <= wb_writereg_d;
      wb_wbvalue_q  <= wb_wbvalue_d;
      selw_q        <= selw_d;
      rd_lat_q      <= rd_lat_d;
      wr_lat_q      <= wr_lat_d;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign mem_mc_en       = en_q;
  assign mem_mc_rw       = rw_q;
  assign mem_mc_addr     = addr_q;
  assign mem_mc_wdata    = wdata_q;
  assign mem_stall       = stall_q;
  assign mem_wb_regdest  = wb_regdest_q;
  assign mem_wb_writereg = wb_writereg_q;
  assign mem_wb_wbvalue  = wb_wbvalue_q;
`ifdef MEM_STAGE_TIMEOUT_EN
  assign mem_err         = err_q;
`else
  assign mem_err         = 1'b0;
`endif

endmodule
